// File: rtl/r5_stage_ctrl_if.sv
// Stream, lane-bus and pipeline-control bundle for the radix-5 stage controller.
// GW is derived from N here and in the controller, so both sides must use the same N.
interface r5_stage_ctrl_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned N  = 25
);
  localparam int unsigned NG = N / 5;
  localparam int unsigned GW = (NG > 1) ? $clog2(NG) : 1;

  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_re;
  logic [DW-1:0]   in_img;
  logic [5*DW-1:0] bf_re;
  logic [5*DW-1:0] bf_img;
  logic            bf_start;
  logic [GW-1:0]   tw_idx;
  logic            stage_en;
  logic            out_valid;
  logic            out_ready;
  logic            out_last;
  logic            frame_done;

  modport slave (
    input  in_valid, in_re, in_img, out_ready,
    output in_ready, bf_re, bf_img, bf_start, tw_idx, stage_en,
           out_valid, out_last, frame_done
  );

  modport master (
    output in_valid, in_re, in_img, out_ready,
    input  in_ready, bf_re, bf_img, bf_start, tw_idx, stage_en,
           out_valid, out_last, frame_done
  );
endinterface

// File: rtl/r5_stage_ctrl.sv
// Radix-5 stage sequencer: packs serial samples into 5 lanes, issues groups to the
// butterfly, and tracks in-flight groups through a LAT-deep stallable pipeline.
module r5_stage_ctrl #(
  parameter int unsigned DW  = 32,
  parameter int unsigned LAT = 4,
  parameter int unsigned N   = 25
) (
  input  logic           clk,
  input  logic           rst_n,
  r5_stage_ctrl_if.slave bus
);
  localparam int unsigned NG = N / 5;
  localparam int unsigned GW = (NG > 1) ? $clog2(NG) : 1;
  localparam int unsigned BW = 5 * DW;
  localparam logic [GW-1:0] GRP_LAST = GW'(NG - 1);

  logic [2:0]     lc_q, lc_d;
  logic [GW-1:0]  grp_q, grp_d;
  logic           full_q, full_d;
  logic [LAT-1:0] vp_q, vp_d;
  logic [LAT-1:0] lp_q, lp_d;
  logic           fdone_q, fdone_d;
  logic [BW-1:0]  re_q, re_d;
  logic [BW-1:0]  im_q, im_d;

  logic stage_en_c, issue_c, in_ready_c, accept_c;

  // Pipeline advances unless the head group is valid and refused downstream.
  always_comb begin
    stage_en_c = !(vp_q[LAT-1] && !bus.out_ready);
    issue_c    = full_q && stage_en_c;
    in_ready_c = rst_n && (!full_q || stage_en_c);
    accept_c   = bus.in_valid && in_ready_c;
  end

  always_comb begin
    lc_d    = lc_q;
    grp_d   = grp_q;
    full_d  = full_q;
    vp_d    = vp_q;
    lp_d    = lp_q;
    re_d    = re_q;
    im_d    = im_q;
    fdone_d = vp_q[LAT-1] && lp_q[LAT-1] && bus.out_ready;

    if (issue_c) begin
      full_d = 1'b0;
      grp_d  = (grp_q == GRP_LAST) ? '0 : grp_q + GW'(1);
    end

    // Lane 0 of the next group may land on the issue edge; the butterfly captures
    // the old lanes on that same edge, so the overwrite is safe.
    if (accept_c) begin
      for (int unsigned k = 0; k < 5; k++) begin
        if (lc_q == 3'(k)) begin
          re_d[k*DW +: DW] = bus.in_re;
          im_d[k*DW +: DW] = bus.in_img;
        end
      end
      if (lc_q == 3'd4) begin
        lc_d   = '0;
        full_d = 1'b1;
      end else begin
        lc_d = lc_q + 3'd1;
      end
    end

    if (stage_en_c) begin
      vp_d = (vp_q << 1) | LAT'(issue_c);
      lp_d = (lp_q << 1) | LAT'(issue_c && (grp_q == GRP_LAST));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lc_q    <= '0;
      grp_q   <= '0;
      full_q  <= 1'b0;
      vp_q    <= '0;
      lp_q    <= '0;
      fdone_q <= 1'b0;
      re_q    <= '0;
      im_q    <= '0;
    end else begin
      lc_q    <= lc_d;
      grp_q   <= grp_d;
      full_q  <= full_d;
      vp_q    <= vp_d;
      lp_q    <= lp_d;
      fdone_q <= fdone_d;
      re_q    <= re_d;
      im_q    <= im_d;
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.bf_re      = re_q;
  assign bus.bf_img     = im_q;
  assign bus.bf_start   = issue_c;
  assign bus.tw_idx     = grp_q;
  assign bus.stage_en   = stage_en_c;
  assign bus.out_valid  = vp_q[LAT-1];
  assign bus.out_last   = vp_q[LAT-1] && lp_q[LAT-1];
  assign bus.frame_done = fdone_q;
endmodule

// File: tb/tb_r5_stage_ctrl.sv
// Directed bench for r5_stage_ctrl: a negedge monitor logs handshakes and issues,
// and the linear stimulus checks them against hand-derived values.
module tb_r5_stage_ctrl;
  localparam int unsigned DW  = 16;
  localparam int unsigned LAT = 6;
  localparam int unsigned N   = 25;
  localparam int unsigned GW  = 3;
  localparam int unsigned BW  = 5 * DW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;

  r5_stage_ctrl_if #(.DW(DW), .N(N)) bus ();
  r5_stage_ctrl #(.DW(DW), .LAT(LAT), .N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_acc = 0;
  int drop_cnt = 0;
  int acc_cyc[$];
  int iss_cyc[$];
  int iss_tw[$];
  logic [BW-1:0] iss_re[$];
  logic [BW-1:0] iss_im[$];
  int out_last_q[$];
  int out_cyc[$];
  int fd_cyc[$];

  always @(negedge clk) begin
    if (bus.in_valid && bus.in_ready) begin
      n_acc++;
      acc_cyc.push_back(cyc);
    end
    if (rst_n && bus.in_valid && !bus.in_ready) drop_cnt++;
    if (bus.bf_start) begin
      iss_cyc.push_back(cyc);
      iss_tw.push_back(int'(bus.tw_idx));
      iss_re.push_back(bus.bf_re);
      iss_im.push_back(bus.bf_img);
    end
    if (bus.out_valid && bus.out_ready) begin
      out_last_q.push_back(int'(bus.out_last));
      out_cyc.push_back(cyc);
    end
    if (bus.frame_done) fd_cyc.push_back(cyc);
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_bus(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] re_of(input int s);
    return DW'(s);
  endfunction

  function automatic logic [DW-1:0] im_of(input int s);
    return DW'(32'h5a00 ^ s);
  endfunction

  // Expected lane bus for a group whose first sample number is s.
  function automatic logic [BW-1:0] lanes(input int s, input bit im);
    logic [BW-1:0] v;
    v = '0;
    for (int k = 0; k < 5; k++) v[k*DW +: DW] = im ? im_of(s + k) : re_of(s + k);
    return v;
  endfunction

  task automatic drive_sample();
    bus.in_re  = re_of(n_acc + 1);
    bus.in_img = im_of(n_acc + 1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: continuous, 1: in_valid every other cycle, 2: out_ready toggling
  task automatic run(input int target, input int ncyc, input int mode);
    for (int c = 0; c < ncyc; c++) begin
      if (mode == 2) bus.out_ready = ((c % 2) == 1);
      bus.in_valid = (n_acc < target) && (mode != 1 || (c % 2) == 0);
      drive_sample();
      tick();
    end
    bus.in_valid = 1'b0;
    if (mode == 2) bus.out_ready = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  int sb, ib, ob, fb, db, ab, ib2, ob2;
  int seen, ok;
  int b_se, b_rdy, b_bs, b_ov, b_ol;
  logic [4:0] pat;

  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_re = '0;
    bus.in_img = '0;

    // Reset values
    tick();
    @(negedge clk);
    chk("rst_in_ready", int'(bus.in_ready), 0);
    chk("rst_stage_en", int'(bus.stage_en), 1);
    chk("rst_bf_start", int'(bus.bf_start), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_last", int'(bus.out_last), 0);
    chk("rst_tw_idx", int'(bus.tw_idx), 0);
    chk("rst_frame_done", int'(bus.frame_done), 0);
    chk_bus("rst_bf_re", bus.bf_re, '0);
    tick();
    rst_n = 1'b1;

    // T1: first group, issue and output latency
    sb = n_acc;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      drive_sample();
      @(negedge clk);
      if (i == 0) chk("t1_in_ready", int'(bus.in_ready), 1);
      if (i == 4) chk("t1_no_early_start", int'(bus.bf_start), 0);
      tick();
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("t1_bf_start", int'(bus.bf_start), 1);
    chk_bus("t1_bf_re", bus.bf_re, lanes(sb + 1, 1'b0));
    chk_bus("t1_bf_img", bus.bf_img, lanes(sb + 1, 1'b1));
    chk("t1_tw_idx", int'(bus.tw_idx), 0);
    tick();
    seen = 0;
    repeat (LAT - 1) begin
      @(negedge clk);
      seen |= int'(bus.out_valid);
      tick();
    end
    chk("t1_out_valid_early", seen, 0);
    @(negedge clk);
    chk("t1_out_valid", int'(bus.out_valid), 1);
    chk("t1_out_last", int'(bus.out_last), 0);
    tick();
    @(negedge clk);
    chk("t1_out_valid_drop", int'(bus.out_valid), 0);
    chk("t1_frame_done", int'(bus.frame_done), 0);
    tick();

    // T2: full frame, continuous
    do_reset();
    sb = n_acc; ib = iss_tw.size(); ob = out_last_q.size(); fb = fd_cyc.size(); db = drop_cnt;
    run(sb + 25, 25 + LAT + 15, 0);
    chk("t2_accepted", n_acc - sb, 25);
    chk("t2_issues", iss_tw.size() - ib, 5);
    if (iss_tw.size() - ib == 5) begin
      for (int g = 0; g < 5; g++) chk($sformatf("t2_tw_%0d", g), iss_tw[ib + g], g);
      ok = 1;
      for (int g = 1; g < 5; g++) if (iss_cyc[ib + g] - iss_cyc[ib + g - 1] != 5) ok = 0;
      chk("t2_issue_spacing", ok, 1);
      chk_bus("t2_g4_re", iss_re[ib + 4], lanes(sb + 21, 1'b0));
    end
    chk("t2_outputs", out_last_q.size() - ob, 5);
    pat = '0;
    if (out_last_q.size() - ob == 5)
      for (int g = 0; g < 5; g++) pat[g] = out_last_q[ob + g][0];
    chk("t2_last_pattern", int'(pat), 16);
    chk("t2_frame_done_cnt", fd_cyc.size() - fb, 1);
    if (fd_cyc.size() - fb == 1 && out_cyc.size() - ob == 5)
      chk("t2_frame_done_cyc", fd_cyc[fb], out_cyc[ob + 4] + 1);
    chk("t2_ready_drops", drop_cnt - db, 0);
    sb = n_acc;
    run(sb + 5, 12, 0);
    chk("t2_next_frame_issues", iss_tw.size() - ib, 6);
    chk("t2_next_frame_tw", iss_tw[iss_tw.size() - 1], 0);

    // T3: stall with two groups in flight and a third full
    do_reset();
    bus.out_ready = 1'b0;
    sb = n_acc; ib = iss_tw.size(); ob = out_last_q.size();
    run(sb + 16, 17, 0);
    b_se = 0; b_rdy = 0; b_bs = 0; b_ov = 0; b_ol = 0;
    repeat (10) begin
      bus.in_valid = 1'b1;
      drive_sample();
      @(negedge clk);
      b_se  |= int'(bus.stage_en);
      b_rdy |= int'(bus.in_ready);
      b_bs  |= int'(bus.bf_start);
      b_ov  |= int'(!bus.out_valid);
      b_ol  |= int'(bus.out_last);
      tick();
    end
    chk("t3_stage_en_low", b_se, 0);
    chk("t3_in_ready_low", b_rdy, 0);
    chk("t3_no_bf_start", b_bs, 0);
    chk("t3_out_valid_held", b_ov, 0);
    chk("t3_out_last_stable", b_ol, 0);
    chk("t3_accepted", n_acc - sb, 15);
    chk("t3_issued_before", iss_tw.size() - ib, 2);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    run(n_acc, 40, 0);
    chk("t3_issues", iss_tw.size() - ib, 3);
    chk("t3_outputs", out_last_q.size() - ob, 3);
    if (iss_tw.size() - ib == 3) begin
      for (int g = 0; g < 3; g++) chk($sformatf("t3_tw_%0d", g), iss_tw[ib + g], g);
      chk_bus("t3_g2_re", iss_re[ib + 2], lanes(sb + 11, 1'b0));
      chk_bus("t3_g2_img", iss_im[ib + 2], lanes(sb + 11, 1'b1));
    end

    // T4: mid-operation reset discards partial and in-flight groups
    do_reset();
    sb = n_acc; ib = iss_tw.size(); ob = out_last_q.size();
    run(sb + 8, 8, 0);
    chk("t4_accepted", n_acc - sb, 8);
    chk("t4_issued", iss_tw.size() - ib, 1);
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("t4_rst_in_ready", int'(bus.in_ready), 0);
    tick();
    rst_n = 1'b1;
    ib2 = iss_tw.size();
    run(n_acc, 20, 0);
    chk("t4_no_issue", iss_tw.size() - ib2, 0);
    chk("t4_no_output", out_last_q.size() - ob, 0);
    sb = n_acc;
    run(sb + 5, 10, 0);
    chk("t4_new_issue", iss_tw.size() - ib2, 1);
    if (iss_tw.size() - ib2 == 1) begin
      chk("t4_new_tw", iss_tw[ib2], 0);
      chk_bus("t4_new_re", iss_re[ib2], lanes(sb + 1, 1'b0));
    end

    // T5: gapped input
    do_reset();
    sb = n_acc; ib = iss_tw.size(); ab = acc_cyc.size();
    run(sb + 10, 30, 1);
    chk("t5_issues", iss_tw.size() - ib, 2);
    if (iss_tw.size() - ib == 2 && acc_cyc.size() - ab == 10) begin
      chk_bus("t5_g0_re", iss_re[ib], lanes(sb + 1, 1'b0));
      chk_bus("t5_g1_img", iss_im[ib + 1], lanes(sb + 6, 1'b1));
      chk("t5_g0_latency", iss_cyc[ib] - acc_cyc[ab + 4], 1);
      chk("t5_g1_latency", iss_cyc[ib + 1] - acc_cyc[ab + 9], 1);
    end

    // T6: out_ready toggling under continuous input
    do_reset();
    sb = n_acc; ib = iss_tw.size(); ob = out_last_q.size(); fb = fd_cyc.size();
    run(sb + 25, 60, 2);
    run(n_acc, 30, 0);
    chk("t6_accepted", n_acc - sb, 25);
    chk("t6_issues", iss_tw.size() - ib, 5);
    chk("t6_outputs", out_last_q.size() - ob, 5);
    pat = '0;
    if (out_last_q.size() - ob == 5)
      for (int g = 0; g < 5; g++) pat[g] = out_last_q[ob + g][0];
    chk("t6_last_pattern", int'(pat), 16);
    chk("t6_frame_done_cnt", fd_cyc.size() - fb, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/r5_stage_ctrl.md
# r5_stage_ctrl

Sequencing controller for one radix-5 butterfly stage. It accepts a serial complex sample stream with valid/ready and packs each run of five samples into a parallel lane register. It issues each complete group to the butterfly datapath and drives the shared clock-enable for the stage's pipeline buffer registers. It tracks in-flight groups through the fixed-latency pipeline and presents results with valid/ready, frame-last and twiddle-index tagging.

## Interface
Parameters:
- DW, 32, width of each real/imaginary component
- LAT, 4, butterfly pipeline depth in buffer stages (≥1)
- N, 25, samples per frame; must be a multiple of 5 and ≥5
- GW, $clog2(N/5) (min 1), width of tw_idx

Ports:
- clk  in  1  rising-edge clock, single clock domain
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  input sample valid
- in_ready  out  1  controller can accept a sample this cycle
- in_re, in_img  in  DW each  input sample
- bf_re, bf_img  out  5*DW each  lane bus to butterfly; lane k at bits [k*DW +: DW]
- bf_start  out  1  one-cycle pulse: bf bus holds a complete group, captured this edge
- tw_idx  out  GW  group index within frame (0..N/5-1), valid with bf_start
- stage_en  out  1  clock enable for all butterfly pipeline buffer registers
- out_valid  in/out: out  1  butterfly output valid (stage LAT)
- out_ready  in  1  downstream accepts output
- out_last  out  1  qualifies out_valid: final group of frame
- frame_done  out  1  one-cycle pulse when the out_last group is accepted

## Operation
- Lane fill: lane counter lc (0..4). Sample accepted when in_valid && in_ready; it is written to lane lc and lc increments. On accepting lane 4, lc wraps to 0 and group_full is set.
- Pipeline advance: stage_en = !(vp[LAT-1] && !out_ready). vp[LAT-1:0] is the valid shift register and lp[LAT-1:0] is the parallel last-tag shift register. Both shift only when stage_en is 1.
- Issue: bf_start = group_full && stage_en (combinational). On issue:
  - vp[0] takes 1; lp[0] takes (grp == N/5-1).
  - grp increments and wraps to 0 after N/5-1.
  - group_full clears unless the same edge completes another group (impossible, see next point).
- When stage_en is 1 and no issue occurs, vp[0] takes 0.
- in_ready = rst_n && (!group_full || stage_en). Lane 0 of the next group may be accepted in the issue cycle; the lane write and the butterfly capture use the same edge, so the issued data is intact.
- Output: out_valid = vp[LAT-1]; out_last = vp[LAT-1] && lp[LAT-1]. frame_done is registered: set for one cycle after an edge where out_valid && out_ready && out_last.
- tw_idx = grp (registered).
- bf_re and bf_img are the lane registers, driven directly.

## Timing
- Reset (rst_n low at an edge):
  - lc, grp, group_full, vp, lp and frame_done are cleared.
  - Lane registers are cleared to 0.
  - Resulting outputs: in_ready=0 while rst_n is low; bf_start=0, out_valid=0, out_last=0, tw_idx=0, stage_en=1.
- Reset mid-operation discards any partial group and all in-flight groups; the next frame starts at grp 0, lane 0.
- Input-to-issue latency: bf_start is asserted in the cycle after the edge that accepts lane 4, unless stalled.
- Issue-to-output latency: out_valid is asserted LAT cycles after the bf_start cycle, plus one cycle per stall cycle in between.
- Throughput: one group per 5 cycles under continuous in_valid and out_ready=1; in_ready never drops.
- Stall: while out_valid && !out_ready, stage_en=0 and vp/lp hold.
  - A full group waits with bf_start=0 and in_ready=0.
  - A partial group keeps filling while !group_full.
- The out_valid and out_last stream is never reordered or dropped. out_valid, once asserted, holds with unchanged tag until accepted.
- Simultaneous output accept and issue on one edge: both shifts take effect; no bubble is inserted.

## Test plan
1. Reset, then 5 back-to-back samples with re=1..5 → bf_start pulses in cycle 6 with bf_re lanes 1..5 and tw_idx=0; out_valid rises in cycle 6+LAT.
2. Continuous 25-sample frame, out_ready=1 → 5 bf_start pulses spaced 5 cycles apart with tw_idx 0,1,2,3,4. out_last is set only on the 5th output; frame_done pulses once, in the cycle after that output is accepted. The next frame restarts at tw_idx=0.
3. out_ready=0 held for 10 cycles with 2 groups in flight and a 3rd group full → stage_en=0, in_ready=0, bf_start=0, out_valid held with stable out_last. On release, the groups are delivered in order with no loss.
4. rst_n pulled low for 1 cycle after 3 samples of group 2 → no bf_start and no out_valid from the discarded data. The following 5 samples issue with tw_idx=0.
5. Gapped input (in_valid toggling every other cycle) → lane order is preserved and bf_start follows the 5th accepted sample by 1 cycle.
6. out_ready toggling every cycle under continuous input → output count equals group count and there are no duplicate handshakes.
